// File: rtl/ex_mem_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_pkg
// Shared definitions for the EX/MEM pipeline register of the 5-stage MIPS
// core: data-path widths, zero constants, write-enable and stall-bit
// encodings, stall-vector indices, the captured write-back request bundle
// and the per-edge update-mode selector.
// ---------------------------------------------------------------------------
package ex_mem_reg_pkg;

  // Data-path widths
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  // Zero constants
  localparam logic [REG_BUS_W-1:0]   ZERO_WORD  = '0;
  localparam logic [2*REG_BUS_W-1:0] ZERO_DWORD = '0;

  // Write-enable encodings
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Stall-bit encodings
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Positions of the execute and memory stages in the global stall vector
  localparam int EX_IDX  = 3;
  localparam int MEM_IDX = 4;

  // Write-back and HI/LO request carried from execute to memory
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_BUS_W-1:0]  wdata;
    logic [REG_BUS_W-1:0]  hi;
    logic [REG_BUS_W-1:0]  lo;
    logic                  whilo;
  } mem_req_t;

  // A bubble is a request that writes nothing
  localparam mem_req_t BUBBLE_REQ = '{
    wd:    '0,
    wreg:  WRITE_DISABLE,
    wdata: ZERO_WORD,
    hi:    ZERO_WORD,
    lo:    ZERO_WORD,
    whilo: WRITE_DISABLE
  };

  // Exactly one of these applies on every rising edge
  typedef enum logic [1:0] {
    MODE_FLUSH,   // forced bubble, accumulate state cleared
    MODE_BUBBLE,  // execute stalled alone: bubble, accumulate state kept
    MODE_PASS,    // execute advances into memory
    MODE_HOLD     // execute and memory both stalled
  } upd_mode_e;

  // Priority: flush, then EX-only stall, then pass, then hold. A memory
  // stall without an execute stall cannot come from the control block and
  // falls into pass-through.
  function automatic upd_mode_e sel_mode(input logic flush,
                                         input logic ex_stall,
                                         input logic mem_stall);
    if (flush)
      return MODE_FLUSH;
    else if (ex_stall == STOP && mem_stall == NO_STOP)
      return MODE_BUBBLE;
    else if (ex_stall == NO_STOP)
      return MODE_PASS;
    else
      return MODE_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one per enabled cycle and stops at its
// all-ones value instead of wrapping. Reusable by every stage register.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}}))
      count_d = count_q + W'(1);
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// Pipeline register between the execute and memory-access stages. Captures
// the register write-back and HI/LO write requests, honours the global stall
// vector (hold when both stages stall, bubble when only execute stalls),
// feeds the multi-cycle accumulate state back to execute, and counts bubbles.
//   clk                 : core clock, rising edge
//   rst                 : asynchronous active-low reset
//   stall               : global stall vector (bit 0 = pc ... bit 5 = wb)
//   flush               : synchronous flush, forces a bubble
//   ex_wd/ex_wreg/ex_wdata          : write-back request from execute
//   ex_hi/ex_lo/ex_whilo            : HI/LO write request from execute
//   hilo_i/cnt_i        : accumulate temporary and cycle count from execute
//   mem_wd/mem_wreg/mem_wdata       : registered write-back request
//   mem_hi/mem_lo/mem_whilo         : registered HI/LO write request
//   hilo_o/cnt_o        : accumulate state fed back to execute
//   bubble_cnt          : saturating count of bubbles inserted since reset
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int STALL_W = 6,
  parameter int EX_IDX  = ex_mem_reg_pkg::EX_IDX,
  parameter int MEM_IDX = ex_mem_reg_pkg::MEM_IDX,
  parameter int BCNT_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [STALL_W-1:0]                     stall,
  input  logic                                   flush,
  input  logic [ex_mem_reg_pkg::REG_ADDR_W-1:0]  ex_wd,
  input  logic                                   ex_wreg,
  input  logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   ex_wdata,
  input  logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   ex_hi,
  input  logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   ex_lo,
  input  logic                                   ex_whilo,
  input  logic [2*ex_mem_reg_pkg::REG_BUS_W-1:0] hilo_i,
  input  logic [1:0]                             cnt_i,
  output logic [ex_mem_reg_pkg::REG_ADDR_W-1:0]  mem_wd,
  output logic                                   mem_wreg,
  output logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   mem_wdata,
  output logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   mem_hi,
  output logic [ex_mem_reg_pkg::REG_BUS_W-1:0]   mem_lo,
  output logic                                   mem_whilo,
  output logic [2*ex_mem_reg_pkg::REG_BUS_W-1:0] hilo_o,
  output logic [1:0]                             cnt_o,
  output logic [BCNT_W-1:0]                      bubble_cnt
);

  import ex_mem_reg_pkg::*;

  upd_mode_e             mode;
  mem_req_t              ex_req;
  mem_req_t              req_q,  req_d;
  logic [2*REG_BUS_W-1:0] hilo_q, hilo_d;
  logic [1:0]            cnt_q,  cnt_d;
  logic                  bubble_inc;

  // Only the execute and memory bits matter here; the rest of the vector
  // belongs to other stage registers.
  logic stall_unused;
  assign stall_unused = ^stall;

  assign mode = sel_mode(flush, stall[EX_IDX], stall[MEM_IDX]);

  assign ex_req = '{
    wd:    ex_wd,
    wreg:  ex_wreg,
    wdata: ex_wdata,
    hi:    ex_hi,
    lo:    ex_lo,
    whilo: ex_whilo
  };

  // NOTE: every next-state signal is given its hold value before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_d  = req_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    case (mode)
      MODE_FLUSH: begin
        req_d  = BUBBLE_REQ;
        hilo_d = ZERO_DWORD;
        cnt_d  = '0;
      end
      MODE_BUBBLE: begin
        // Execute is still iterating a madd/msub: hand its state back.
        req_d  = BUBBLE_REQ;
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      MODE_PASS: begin
        req_d  = ex_req;
        hilo_d = ZERO_DWORD;
        cnt_d  = '0;
      end
      default: ;  // MODE_HOLD keeps everything
    endcase
  end

  assign bubble_inc = (mode == MODE_FLUSH) || (mode == MODE_BUBBLE);

  // Asynchronous reset also discards any partially accumulated madd/msub
  // state; execute restarts the instruction afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= BUBBLE_REQ;
      hilo_q <= ZERO_DWORD;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  sat_counter #(
    .W(BCNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (bubble_inc),
    .count_o (bubble_cnt)
  );

  assign mem_wd    = req_q.wd;
  assign mem_wreg  = req_q.wreg;
  assign mem_wdata = req_q.wdata;
  assign mem_hi    = req_q.hi;
  assign mem_lo    = req_q.lo;
  assign mem_whilo = req_q.whilo;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute stage's register write-back request and its HI/LO write request every cycle.
- Honours the global stall vector: holds when both stages stall, and inserts a bubble when only execute stalls.
- Carries the multi-cycle accumulate state (64-bit temporary, 2-bit cycle count) back to the execute stage for madd/msub sequencing. Keeps a saturating bubble counter for debug.

Parameters:
- STALL_W, 6, width of the global stall vector (bit 0 = pc … bit 5 = wb).
- EX_IDX, 3, stall bit index of the execute stage.
- MEM_IDX, 4, stall bit index of the memory stage.
- BCNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; asserted when low.
- stall  in  STALL_W  global stall vector from the control block.
- flush  in  1  synchronous pipeline flush; forces a bubble.
- ex_wd  in  5  destination register address from execute.
- ex_wreg  in  1  register write enable from execute.
- ex_wdata  in  32  write-back data from execute.
- ex_hi  in  32  HI write value from execute.
- ex_lo  in  32  LO write value from execute.
- ex_whilo  in  1  HI/LO write enable from execute.
- hilo_i  in  64  accumulate temporary produced by execute this cycle.
- cnt_i  in  2  accumulate cycle count produced by execute this cycle.
- mem_wd  out  5  registered destination address to memory stage.
- mem_wreg  out  1  registered register write enable.
- mem_wdata  out  32  registered write-back data.
- mem_hi  out  32  registered HI value.
- mem_lo  out  32  registered LO value.
- mem_whilo  out  1  registered HI/LO write enable.
- hilo_o  out  64  accumulate temporary fed back to execute.
- cnt_o  out  2  accumulate cycle count fed back to execute.
- bubble_cnt  out  BCNT_W  number of bubbles inserted since reset; saturates.

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0, including bubble_cnt. Release is sampled on the next rising edge.
- Exactly one update mode applies per rising edge, in this priority order:
  1. flush=1: load a bubble. Clear hilo_o and cnt_o to 0. Increment bubble_cnt. Flush overrides stall.
  2. stall[EX_IDX]=1 and stall[MEM_IDX]=0: load a bubble. Set hilo_o<=hilo_i and cnt_o<=cnt_i so execute can resume the multi-cycle op. Increment bubble_cnt.
  3. stall[EX_IDX]=0: pass through. Every mem_* output takes its ex_* counterpart. Clear hilo_o and cnt_o to 0.
  4. stall[EX_IDX]=1 and stall[MEM_IDX]=1: hold. All outputs keep their value and bubble_cnt does not change.
- A bubble sets mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo and mem_whilo all to 0.
- The combination stall[MEM_IDX]=1 with stall[EX_IDX]=0 is illegal from the control block. The block treats it as pass-through (mode 3); the verification engineer flags it with an assertion.
- Latency: 1 cycle from ex_* to mem_*. There is no combinational path from any input to any output.
- bubble_cnt: increments by 1 on each bubble load and stops at 2^BCNT_W−1 (no wrap).
- Width rules: hilo_i, hilo_o, cnt_i and cnt_o are captured verbatim. There is no arithmetic on the data path.
- Reset mid-operation: an asynchronous assertion clears all state immediately, including a partially accumulated hilo_o and cnt_o. The execute stage restarts the instruction after reset.

Decomposition:
- Shared definitions header holds:
  - ZeroWord and the 64-bit zero;
  - the register-bus and register-address widths;
  - WriteEnable and WriteDisable;
  - Stop and NoStop, the stall-bit values.
  - Stall-index constants EX_IDX and MEM_IDX belong there too.
- A sub-module is optional: sat_counter (parameterised width, increment enable, saturate). It is used for bubble_cnt and reusable by other stage registers. Everything else stays in one module.

Test Plan:
- Reset: hold rst low for 3 cycles with ex_wdata=32'hDEADBEEF → all outputs stay 0. One cycle after release with stall=0: mem_wdata=32'hDEADBEEF.
- Pass-through: ex_wd=5'd8, ex_wreg=1, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB, stall=0 → next cycle mem_wd=8, mem_wdata=32'h12345678, mem_hi=32'hA, mem_lo=32'hB, hilo_o=0, cnt_o=0.
- EX-only stall: stall=6'b001111, hilo_i=64'h1_0000_0002, cnt_i=2'd1 → next cycle all mem_*=0, hilo_o=64'h1_0000_0002, cnt_o=1, bubble_cnt=1. Then stall=0 → hilo_o=0, cnt_o=0 and ex data appears.
- Hold: load mem_wdata=32'h55, then apply stall=6'b011111 for 4 cycles → mem_wdata stays 32'h55 and bubble_cnt is unchanged.
- Flush over stall: flush=1 with stall=6'b011111 → next cycle all mem_*=0, hilo_o=0, cnt_o=0, bubble_cnt incremented by 1.
- Saturation and async reset: force BCNT_W=2 and apply 5 EX-only stalls → bubble_cnt=3. Drop rst low mid-cycle → bubble_cnt=0 and cnt_o=0 before the next edge.
